dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: the processor data port (requester 0, default priority) and a debug/program-loader port (requester 1).
- Sits between the processor's data interface and the data memory; drives the word address (byte addr[31:3]), write enable, write data and byte mask.
- Stalls the processor when the loader owns the memory.
- Bounds starvation in both directions with a forced-grant counter and a lock timeout.

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the processor data port and a debug/loader port share one
// single-port memory. The CPU has default priority. Two limits keep either side
// from starving the other:
//   - a wait counter force-grants the debug port after MAX_WAIT cycles of waiting;
//   - a lock timeout ends a locked debug burst after LOCK_MAX grants if the CPU
//     is requesting.
//
// state  | meaning
// S_CPU  | normal arbitration, CPU wins unless debug has waited MAX_WAIT cycles
// S_LOCK | debug holds the memory for consecutive locked accesses
module dmem_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int LOCK_MAX = 16,
  parameter int ADDR_W   = 29
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_wr_en,
  input  logic [63:0]       cpu_wdata,
  input  logic [7:0]        cpu_wmask,
  output logic [63:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_lock,
  input  logic [31:0]       dbg_addr,
  input  logic              dbg_wr_en,
  input  logic [63:0]       dbg_wdata,
  input  logic [7:0]        dbg_wmask,
  output logic              dbg_gnt,
  output logic [63:0]       dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [63:0]       mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {S_CPU, S_LOCK} state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic [LOCK_W-1:0]   lock_cnt, lock_nxt;
  logic                cpu_req_v, dbg_req_v;
  logic                gnt_d, gnt_c, locked_gnt;

  // Requests are masked while reset is held so grants, stall and write enable
  // drop the moment nrst falls, not at the next clock edge.
  assign cpu_req_v = cpu_req & nrst;
  assign dbg_req_v = dbg_req & nrst;

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[2:0], dbg_addr[2:0]};

  // State, counters and registered debug read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_CPU;
      wait_cnt   <= '0;
      lock_cnt   <= '0;
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      lock_cnt   <= lock_nxt;
      dbg_rvalid <= gnt_d & ~dbg_wr_en;
      if (gnt_d & ~dbg_wr_en) dbg_rdata <= mem_rdata;
    end
  end

  // Grant decision, next state and counter updates.
  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    lock_nxt   = lock_cnt;
    locked_gnt = 1'b0;
    gnt_d      = 1'b0;
    case (state)
      S_LOCK: begin
        locked_gnt = dbg_req_v & dbg_lock &
                     ((lock_cnt < LOCK_W'(LOCK_MAX)) | ~cpu_req_v);
        // Fallback to plain CPU-priority rules with a fresh wait count.
        gnt_d = locked_gnt | (dbg_req_v & ~cpu_req_v);
      end
      default: begin
        gnt_d = dbg_req_v & (~cpu_req_v | (wait_cnt == WAIT_W'(MAX_WAIT)));
      end
    endcase
    gnt_c = cpu_req_v & ~gnt_d;

    if (gnt_d | ~dbg_req_v) wait_nxt = '0;
    else if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_nxt = wait_cnt + 1'b1;

    case (state)
      S_LOCK: begin
        if (locked_gnt) begin
          if (lock_cnt != LOCK_W'(LOCK_MAX)) lock_nxt = lock_cnt + 1'b1;
        end else begin
          state_nxt = S_CPU;
          lock_nxt  = '0;
          wait_nxt  = '0;
        end
      end
      default: begin
        if (gnt_d & dbg_lock) begin
          state_nxt = S_LOCK;
          lock_nxt  = LOCK_W'(1);
        end
      end
    endcase
  end

  // Memory mux: debug fields when debug is granted, CPU fields otherwise.
  always_comb begin
    if (gnt_d) begin
      mem_addr  = dbg_addr[3 +: ADDR_W];
      mem_wdata = dbg_wdata;
      mem_wmask = dbg_wmask;
      mem_wr_en = dbg_wr_en;
    end else begin
      mem_addr  = cpu_addr[3 +: ADDR_W];
      mem_wdata = cpu_wdata;
      mem_wmask = cpu_wmask;
      mem_wr_en = gnt_c & cpu_wr_en;
    end
  end

  assign dbg_gnt   = gnt_d;
  assign cpu_stall = cpu_req_v & ~gnt_c;
  assign cpu_rdata = mem_rdata;

endmodule
